// File: rtl/lz77_decoder.sv
// lz77_decoder: rebuilds a byte stream from (offset, match_len, char_nxt)
// tokens. It emits one byte per cycle from a 9-entry shift-register search
// buffer and stops after it emits the literal terminator.
// Optional build macro LZ77_DEC_CHECK_EN adds a fill counter and a sticky
// err flag for illegal offsets. Without the macro, err is tied low.
module lz77_decoder #(
  parameter int          SB_DEPTH  = 9,
  parameter logic [7:0]  TERM_CHAR = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [3:0] offset,
  input  logic [2:0] match_len,
  input  logic [7:0] char_nxt,
  output logic       ready,
  output logic       out_valid,
  output logic [7:0] char_out,
  output logic       finish,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_LIT, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 off_q, off_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [7:0]                 chr_q, chr_d;
  logic [SB_DEPTH-1:0][7:0]   sb_q, sb_d;
  logic                       ov_q, ov_d;
  logic [7:0]                 co_q, co_d;
  logic                       fin_q, fin_d;
  logic                       emit;
  logic [7:0]                 emit_byte;
  logic [7:0]                 rd_byte;

  // Search-buffer read. Offsets past the last entry return 8'h00.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < SB_DEPTH; i++)
      if (off_q == 4'(i)) rd_byte = sb_q[i];
  end

  // Next-state and datapath decode. ready is a pure function of state.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    chr_d     = chr_q;
    sb_d      = sb_q;
    ov_d      = 1'b0;
    co_d      = co_q;
    fin_d     = fin_q;
    emit      = 1'b0;
    emit_byte = chr_q;
    ready     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          off_d   = offset;
          cnt_d   = match_len;
          chr_d   = char_nxt;
          state_d = (match_len != 3'd0) ? S_COPY : S_LIT;
        end
      end
      S_COPY: begin
        // The offset stays fixed while the buffer shifts, so overlapping
        // copies re-read bytes this token has just produced.
        emit      = 1'b1;
        emit_byte = rd_byte;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_LIT;
      end
      S_LIT: begin
        emit      = 1'b1;
        emit_byte = chr_q;
        if (chr_q == TERM_CHAR) begin
          state_d = S_DONE;
          fin_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    if (emit) begin
      ov_d = 1'b1;
      co_d = emit_byte;
      sb_d = {sb_q[SB_DEPTH-2:0], emit_byte};
    end
  end

  // State and datapath registers. Reset discards any partial token.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      cnt_q   <= '0;
      chr_q   <= '0;
      sb_q    <= '0;
      ov_q    <= 1'b0;
      co_q    <= 8'h00;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      chr_q   <= chr_d;
      sb_q    <= sb_d;
      ov_q    <= ov_d;
      co_q    <= co_d;
      fin_q   <= fin_d;
    end
  end

  assign out_valid = ov_q;
  assign char_out  = co_q;
  assign finish    = fin_q;

`ifdef LZ77_DEC_CHECK_EN
  localparam logic [3:0] DEPTH4 = 4'(SB_DEPTH);

  logic [3:0] fill_q, fill_d;
  logic       err_q, err_d;

  // fill saturates at the buffer depth. err flags offsets past the end,
  // and copies from entries that have never been written.
  always_comb begin
    fill_d = fill_q;
    err_d  = err_q;
    if (emit && fill_q != DEPTH4) fill_d = fill_q + 4'd1;
    if (state_q == S_IDLE && valid) begin
      if (offset >= DEPTH4 || (match_len != 3'd0 && offset >= fill_q))
        err_d = 1'b1;
    end
  end

  // Check-state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// Testbench for lz77_decoder. It runs directed and random token streams
// against a history-queue reference model of the decompressor.
module tb_lz77_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] offset = '0;
  logic [2:0] match_len = '0;
  logic [7:0] char_nxt = '0;
  logic       ready, out_valid, finish, err;
  logic [7:0] char_out;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] hist[$];     // every byte emitted since the last reset
  bit         merr = 1'b0; // model of sticky err

  lz77_decoder dut (
    .clk(clk), .reset(reset), .valid(valid), .offset(offset),
    .match_len(match_len), .char_nxt(char_nxt), .ready(ready),
    .out_valid(out_valid), .char_out(char_out), .finish(finish), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A byte at distance o back in history. Entries never written read as 0,
  // and so do offsets beyond the 9-byte window.
  function automatic logic [7:0] ref_byte(input int o);
    if (o < 9 && o < hist.size()) return hist[hist.size()-1-o];
    return 8'h00;
  endfunction

  // Reset with a token also presented, because reset must win over valid.
  task automatic do_reset();
    reset = 1'b1; valid = 1'b1; offset = '0; match_len = '0; char_nxt = "p";
    @(posedge clk); #1;
    reset = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_char_out", char_out, 0);
    chk("rst_finish", finish, 0);
    chk("rst_err", err, 0);
    hist.delete();
    merr = 1'b0;
  endtask

  // Send one token and check every byte it produces. When has_nxt is set,
  // the next token is put on the bus with valid high during decode.
  // That exercises backpressure.
  task automatic tok(input int o, input int l, input logic [7:0] c,
                     input bit has_nxt = 1'b0, input int no = 0,
                     input int nl = 0, input logic [7:0] nc = 8'h00);
    logic [7:0] exp;
    bit         term;
    valid = 1'b1; offset = o[3:0]; match_len = l[2:0]; char_nxt = c;
    chk("ready_idle", ready, 1);
`ifdef LZ77_DEC_CHECK_EN
    if (o >= 9 || (l != 0 && o >= hist.size())) merr = 1'b1;
`endif
    @(posedge clk); #1;
    if (has_nxt) begin
      offset = no[3:0]; match_len = nl[2:0]; char_nxt = nc;
    end else begin
      valid = 1'b0;
    end
    @(negedge clk);
    chk("busy_ready", ready, 0);
    chk("gap_out_valid", out_valid, 0);
    for (int k = 0; k <= l; k++) begin
      @(negedge clk);
      exp = (k == l) ? c : ref_byte(o);
      chk("out_valid", out_valid, 1);
      chk("char_out", char_out, exp);
      hist.push_back(exp);
    end
    term = (c == 8'h24);
    chk("ready_after", ready, !term);
    chk("finish", finish, term);
    chk("err", err, merr);
  endtask

  task automatic check_done();
    repeat (3) begin
      @(negedge clk);
      chk("done_out_valid", out_valid, 0);
      chk("done_finish", finish, 1);
      chk("done_ready", ready, 0);
    end
  endtask

  initial begin
    int         o, l;
    logic [7:0] c;

    // Literal-only stream ending in the terminator.
    do_reset();
    tok(0, 0, "A");
    tok(0, 0, "B");
    tok(0, 0, "$");
    check_done();

    // Overlapping copy.
    do_reset();
    tok(0, 0, "a");
    tok(0, 7, "b");

    // Copy from the oldest entry.
    do_reset();
    for (int i = 0; i < 9; i++) tok(0, 0, 8'h30 + 8'(i));
    tok(8, 3, "x");

    // Backpressure: the second token is held on the bus during the first copy.
    tok(0, 0, "m");
    tok(0, 5, "n", 1'b1, 1, 2, "o");
    tok(1, 2, "o");

    // Reset in the middle of a copy. The next token reads a cleared buffer.
    do_reset();
    tok(0, 0, "y");
    valid = 1'b1; offset = 4'd0; match_len = 3'd7; char_nxt = "z";
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("midcopy_out_valid", out_valid, 1);
      chk("midcopy_char", char_out, "y");
    end
    do_reset();
    tok(3, 2, "k");

    // Illegal tokens.
    do_reset();
    tok(2, 1, "q");
    tok(12, 0, "r");

    // Random token stream, then the terminator.
    do_reset();
    for (int t = 0; t < 60; t++) begin
      o = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8);
      l = $urandom_range(0, 7);
      c = 8'($urandom_range(0, 255));
      if (c == 8'h24) c = 8'h25;
      tok(o, l, c);
    end
    tok($urandom_range(0, 8), $urandom_range(0, 7), "$");
    check_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
